booth_sequencer: RTL and testbench
==================================

// Module: booth_sequencer
// PURPOSE
//  Radix-2 Booth multiply sequencer for the P2 multiplier datapath. Owns the
//  A/Q/Q-1 accumulator-shift registers and iteration counter and drives the
//  shared operand bus of the external registered adder and subtractor. Both
//  units compute every cycle, with 1-cycle latency. Start/ready/done handshake
//  to the requester; signed WIDTH x WIDTH -> 2*WIDTH product.
// PARAMETERS
//  WIDTH   16   operand width (two's complement); product is 2*WIDTH
//  CNT_W   5    iteration counter width; must hold WIDTH
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        synchronous, active-low reset
//  start         in   1        request; accepted only when ready=1
//  multiplicand  in   WIDTH    M, sampled on accepted start
//  multiplier    in   WIDTH    Q, sampled on accepted start
//  ready         out  1        high in IDLE only
//  done          out  1        1-cycle pulse, product valid
//  product       out  2*WIDTH  {A,Q} result; held until next accepted start
//  op_a          out  WIDTH    operand 1 to adder/subtractor (= A)
//  op_b          out  WIDTH    operand 2 to adder/subtractor (= M)
//  sum_in        in   WIDTH    registered adder result (op_a+op_b, prev cycle)
//  diff_in       in   WIDTH    registered subtractor result (op_a-op_b, prev cycle)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; A, Q, Q_1, M, count, product = 0;
//   ready=1; done=0. Applies in every state and aborts any operation.
//   Next start is accepted normally.
//  FSM, one transition per clk:
//  - IDLE: ready=1. start=1 -> latch M, Q; A=0, Q_1=0, count=WIDTH; go EVAL.
//  - EVAL: decode {Q[0],Q_1}:
//     01 -> op=ADD, go WAIT;
//     10 -> op=SUB, go WAIT;
//     00/11 -> op=NOP, go SHIFT.
//    op_a=A and op_b=M are driven continuously from the registers.
//  - WAIT: result is valid on sum_in/diff_in. Capture A <= (ADD ? sum_in : diff_in).
//    Capture ovf = signed overflow from the EVAL operand signs and the result
//    sign. Go SHIFT.
//  - SHIFT: arithmetic right shift of {A,Q,Q_1} by 1. The new A MSB is the true
//    sign: A[W-1]^ovf after ADD/SUB, else A[W-1]. Clear ovf; count <= count-1.
//    If count==1 -> DONE, else EVAL.
//  - DONE: product <= {A,Q}; done=1 for exactly this cycle; ready=0; go IDLE.
//  Arithmetic: all values are WIDTH-bit two's complement; sum/diff wrap mod 2^WIDTH.
//   The overflow-corrected shift makes M=-2^(WIDTH-1) exact.
//  Timing: accept edge -> EVAL next cycle. Each bit costs 2 cycles (NOP) or
//   3 cycles (ADD/SUB), then 1 DONE cycle. Start-to-done latency is
//   1 + 2*WIDTH + (#ADD/SUB bits) + 1 cycles (WIDTH=16: 34..50).
//  start while ready=0 (EVAL/WAIT/SHIFT/DONE) is ignored; it is not queued.
//  Inputs multiplicand/multiplier may change after accept without effect.
//  start held high across DONE->IDLE is accepted in the IDLE cycle.
//   Back-to-back operation is allowed.
//  product updates only in DONE. Between operations it keeps the last result.
// TESTING
//  1. 3 x 5: done after 38 cycles; product=32'h0000_000F.
//  2. -7 x 6 (16'hFFF9 x 16'h0006): product=32'hFFFF_FFD6 (-42).
//  3. 16'h8000 x 16'h8000: product=32'h4000_0000. Checks overflow-corrected shift.
//  4. 16'h1234 x 0: all NOP, done exactly 34 cycles after accept;
//     product=0. Also 0x7FFF x 0x7FFF -> 32'h3FFF_0001.
//  5. Start 5x5; pulse start with 9x9 mid-op: ignored, product=25.
//     Then hold start through done: next op is accepted in the IDLE cycle.
//  6. Assert rst=0 in WAIT mid-op: next cycle ready=1, done=0, product=0.
//     New 2x-3 then completes with product=32'hFFFF_FFFA.

Source files
------------

// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth signed multiply sequencer driving an external registered adder/subtractor
module booth_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic [WIDTH-1:0]   diff_in
);
    typedef enum logic [2:0] {IDLE, EVAL, WAIT, SHIFT, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, m_q, m_d, res;
    logic               q1_q, q1_d, sub_q, sub_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    assign res     = sub_q ? diff_in : sum_in;
    assign ready   = state_q == IDLE;
    assign done    = state_q == DONE;
    assign product = done ? {a_q, q_q} : prod_q;
    assign op_a    = a_q;
    assign op_b    = m_q;

    // Next-state and datapath update for each Booth step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        sub_d   = sub_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (start) begin
                m_d     = multiplicand;
                q_d     = multiplier;
                a_d     = '0;
                q1_d    = 1'b0;
                cnt_d   = CNT_W'(WIDTH);
                state_d = EVAL;
            end
            EVAL: begin
                sub_d   = q_q[0];
                state_d = (q_q[0] ^ q1_q) ? WAIT : SHIFT;
            end
            WAIT: begin
                a_d     = res;
                ovf_d   = (a_q[WIDTH-1] ^ res[WIDTH-1]) &
                          (sub_q ? (a_q[WIDTH-1] ^ m_q[WIDTH-1]) : ~(a_q[WIDTH-1] ^ m_q[WIDTH-1]));
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = {a_q[WIDTH-1] ^ ovf_q, a_q[WIDTH-1:1]};
                q_d     = {a_q[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                ovf_d   = 1'b0;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? DONE : EVAL;
            end
            DONE: begin
                prod_d  = {a_q, q_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: directed-vector bench for booth_sequencer with a registered adder/subtractor model
module tb_booth_sequencer;
    logic        clk, rst, start, ready, done;
    logic [15:0] multiplicand, multiplier, op_a, op_b, sum_in, diff_in;
    logic [31:0] product;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] prod;
        int          lat;
    } vec_t;
    vec_t vec[9];

    booth_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
        .multiplier(multiplier), .ready(ready), .done(done), .product(product),
        .op_a(op_a), .op_b(op_b), .sum_in(sum_in), .diff_in(diff_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder and subtractor, one cycle of latency
    always_ff @(posedge clk) begin
        sum_in  <= op_a + op_b;
        diff_in <= op_a - op_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // n0 is the cycle number just after the accept edge; the accept cycle is 1
    task automatic wait_done(input int n0, output int lat);
        int n;
        n = n0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp, output logic [31:0] p, output int lat);
        start = 1'b1; multiplicand = mc; multiplier = mp;
        @(posedge clk); #1;
        start = 1'b0; multiplicand = ~mc; multiplier = ~mp;
        wait_done(2, lat);
        p = product;
    endtask

    initial begin
        logic [31:0] p;
        int lat;
        vec[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 38};
        vec[1] = '{16'hFFF9, 16'h0006, 32'hFFFF_FFD6, 36};
        vec[2] = '{16'h8000, 16'h8000, 32'h4000_0000, 35};
        vec[3] = '{16'h1234, 16'h0000, 32'h0000_0000, 34};
        vec[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 36};
        vec[5] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, 35};
        vec[6] = '{16'h7FFF, 16'h8000, 32'hC000_8000, 35};
        vec[7] = '{16'h8000, 16'h7FFF, 32'hC000_8000, 36};
        vec[8] = '{16'h0001, 16'h8000, 32'hFFFF_8000, 35};
        rst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_product", product, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            run_op(vec[i].mc, vec[i].mp, p, lat);
            check($sformatf("v%0d_product", i), p, vec[i].prod);
            check($sformatf("v%0d_latency", i), lat, vec[i].lat);
            @(posedge clk); #1;
            check($sformatf("v%0d_held", i), product, vec[i].prod);
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
        end
        // start pulsed mid-operation must be ignored
        start = 1'b1; multiplicand = 16'd5; multiplier = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_ready", {31'b0, ready}, 32'd0);
        start = 1'b1; multiplicand = 16'd9; multiplier = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(13, lat);
        check("ignore_product", product, 32'd25);
        check("ignore_latency", lat, 38);
        @(posedge clk); #1;
        // start held through DONE is accepted in the following IDLE cycle
        start = 1'b1; multiplicand = 16'd3; multiplier = 16'd5;
        @(posedge clk); #1;
        multiplicand = 16'd2; multiplier = 16'd2;
        wait_done(2, lat);
        check("hold_first_product", product, 32'd15);
        check("hold_first_latency", lat, 38);
        @(posedge clk); #1;
        check("hold_idle_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        check("hold_accepted", {31'b0, ready}, 32'd0);
        start = 1'b0;
        wait_done(2, lat);
        check("hold_second_product", product, 32'd4);
        check("hold_second_latency", lat, 36);
        @(posedge clk); #1;
        // reset asserted while in WAIT aborts the operation
        start = 1'b1; multiplicand = 16'd3; multiplier = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_product", product, 32'd0);
        rst = 1'b1;
        run_op(16'd2, 16'hFFFD, p, lat);
        check("after_abort_product", p, 32'hFFFF_FFFA);
        check("after_abort_latency", lat, 37);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
